fir_reload_sat: RTL and testbench
=================================

FIR_RELOAD_SAT -- requirements
Module: fir_reload_sat

Interface
REQ-001 SHALL have parameter C_S_DATA_TDATA_WIDTH, default 16: signed input sample width per channel.
REQ-002 SHALL have parameter C_M_DATA_TDATA_WIDTH, default 16: signed output sample width per channel.
REQ-003 SHALL have parameter C_RELOAD_TDATA_WIDTH, default 16: signed coefficient width.
REQ-004 SHALL have parameter DATA_PATH, default 1: number of independent parallel channels sharing the coefficients.
REQ-005 SHALL have parameter C_NUM_TAPS, default 4: filter length, at least 2.
REQ-006 SHALL have parameter C_OUT_SHIFT, default C_RELOAD_TDATA_WIDTH-1: right shift applied to the accumulator before rounding.
REQ-007 SHALL have parameter C_COEF_FILE, default "": hex file for the initial active bank; empty means all zeros.
REQ-008 SHALL have port aclk, input, 1: the single clock; all logic on its rising edge.
REQ-009 SHALL have port aresetn, input, 1: reset, asynchronous and active-low.
REQ-010 SHALL have port s_axis_reload_tvalid, input, 1: coefficient word valid; always accepted.
REQ-011 SHALL have port s_axis_reload_tlast, input, 1: marks the final coefficient word.
REQ-012 SHALL have port s_axis_reload_tdata, input, C_RELOAD_TDATA_WIDTH: coefficient word; the first word is h[0].
REQ-013 SHALL have port s_axis_config_tvalid, input, 1: single-cycle request to swap the banks.
REQ-014 SHALL have port s_axis_data_tvalid, input, 1: sample valid; always accepted.
REQ-015 SHALL have port s_axis_data_tdata, input, C_S_DATA_TDATA_WIDTH*DATA_PATH: samples, channel k at bits [k*W +: W].
REQ-016 SHALL have port m_axis_data_tvalid, output, 1: output valid.
REQ-017 SHALL have port m_axis_data_tdata, output, C_M_DATA_TDATA_WIDTH*DATA_PATH: outputs, packed the same way as the input.
REQ-018 SHALL have port event_reload_err, output, 1: one-cycle pulse on a malformed reload.
REQ-019 SHALL have port event_config_ignored, output, 1: one-cycle pulse when a swap request is refused.

Function
REQ-020 SHALL hold two coefficient banks, active and shadow; reloads write only the shadow bank.
REQ-021 SHALL write the reload word into shadow[idx]; idx counts from 0, advances on each accepted word and saturates at C_NUM_TAPS; words arriving at idx equal to C_NUM_TAPS are dropped.
REQ-022 SHALL, on a tlast word, return idx to 0 and set shadow_valid if the word count including tlast equals C_NUM_TAPS.
REQ-023 SHALL, on a tlast word with any other count, clear shadow_valid and pulse event_reload_err the next cycle.
REQ-024 SHALL, on s_axis_config_tvalid with shadow_valid set at cycle start, swap the banks at that edge and clear shadow_valid.
REQ-025 SHALL, on s_axis_config_tvalid with shadow_valid clear (including a tlast in the same cycle), leave the banks unchanged and pulse event_config_ignored.
REQ-026 SHALL, per channel, shift each accepted sample into a C_NUM_TAPS-deep delay line that holds x[n]..x[n-C_NUM_TAPS+1]; the delay line is unaffected by a swap.
REQ-027 SHALL compute y[n] = sum over j of h[j]*x[n-j] using the active bank.
REQ-028 SHALL use the new bank for samples accepted in the swap cycle or later, and the old bank for earlier samples.
REQ-029 SHALL use an accumulator of width IN+COEF+clog2(C_NUM_TAPS) bits, signed, with no internal overflow.
REQ-030 SHALL form the output as (acc + 2^(C_OUT_SHIFT-1)) >>> C_OUT_SHIFT, i.e. round half up; with C_OUT_SHIFT=0 there is no rounding term.
REQ-031 SHALL assert m_axis_data_tvalid exactly 2 cycles after each accepted sample, with y[n] on tdata; no backpressure.
REQ-032 SHALL hold m_axis_data_tdata stable while m_axis_data_tvalid is low.

Reset
REQ-033 SHALL, while aresetn is low, immediately clear m_axis_data_tvalid, m_axis_data_tdata, both event outputs, all delay lines, idx, shadow_valid and the pipeline valids.
REQ-034 SHALL leave the coefficient banks and the bank selection unreset, keeping their C_COEF_FILE or zero initial values.
REQ-035 SHALL, after reset is released mid-stream, compute the first outputs from zero history.

Configuration
REQ-036 SHALL, when macro FIR_RELOAD_SAT_SATURATE_EN is defined, clamp the rounded result to [-2^(OUT-1), 2^(OUT-1)-1].
REQ-037 SHALL, when FIR_RELOAD_SAT_SATURATE_EN is not defined, keep the low C_M_DATA_TDATA_WIDTH bits of the rounded result (wrap).

Verification
REQ-038 SHALL cover impulse (16/16/16, 4 taps, shift 15): load 0x4000,0x2000,0x1000,0x0800 with tlast on the 4th word, pulse config, feed 0x7FFF then zeros -> outputs 0x4000,0x2000,0x1000,0x0800,0x0000, each 2 cycles after its input.
REQ-039 SHALL cover overflow: all taps 0x7FFF, input held at 0x7FFF -> 4th and later outputs 0x7FFF with the macro, 0xFFF8 without it.
REQ-040 SHALL cover a malformed reload: 3 words with tlast, then config -> event_reload_err pulse, then event_config_ignored pulse, outputs still from the old bank.
REQ-041 SHALL cover a swap while streaming: config pulsed in the same cycle as sample n -> y[n-1] uses the old bank, y[n] uses the new bank over the unchanged history.
REQ-042 SHALL cover reset mid-stream: aresetn low for 3 cycles between samples -> tvalid and tdata are 0 at once; after release an impulse gives a clean response with no residue.
REQ-043 SHALL cover DATA_PATH=2: impulse on channel 0, constant 0x1000 on channel 1 -> each channel's output is independent and correct.

Source files
------------

// File: rtl/fir_reload_sat.sv
// Multi-channel FIR with double-buffered coefficient reload and bank swap.
// Define FIR_RELOAD_SAT_SATURATE_EN to clamp outputs instead of wrapping.
module fir_reload_sat #(
    parameter int    C_S_DATA_TDATA_WIDTH = 16,
    parameter int    C_M_DATA_TDATA_WIDTH = 16,
    parameter int    C_RELOAD_TDATA_WIDTH = 16,
    parameter int    DATA_PATH            = 1,
    parameter int    C_NUM_TAPS           = 4,
    parameter int    C_OUT_SHIFT          = C_RELOAD_TDATA_WIDTH - 1,
    parameter string C_COEF_FILE          = ""
) (
    input  logic                                           aclk,
    input  logic                                           aresetn,
    input  logic                                           s_axis_reload_tvalid,
    input  logic                                           s_axis_reload_tlast,
    input  logic [C_RELOAD_TDATA_WIDTH-1:0]                s_axis_reload_tdata,
    input  logic                                           s_axis_config_tvalid,
    input  logic                                           s_axis_data_tvalid,
    input  logic [C_S_DATA_TDATA_WIDTH*DATA_PATH-1:0]      s_axis_data_tdata,
    output logic                                           m_axis_data_tvalid,
    output logic [C_M_DATA_TDATA_WIDTH*DATA_PATH-1:0]      m_axis_data_tdata,
    output logic                                           event_reload_err,
    output logic                                           event_config_ignored
);

    localparam int IW  = C_S_DATA_TDATA_WIDTH;
    localparam int OW  = C_M_DATA_TDATA_WIDTH;
    localparam int CW  = C_RELOAD_TDATA_WIDTH;
    localparam int DP  = DATA_PATH;
    localparam int NT  = C_NUM_TAPS;
    localparam int SH  = C_OUT_SHIFT;
    localparam int PW  = IW + CW;
    localparam int AW  = PW + $clog2(NT);
    localparam int XW  = $clog2(NT + 1);
    localparam int AX  = (NT > 1) ? $clog2(NT) : 1;
    localparam int RSH = (SH > 0) ? SH - 1 : 0;

    localparam logic signed [AW:0] RND  = (SH > 0) ? ((AW+1)'(1) <<< RSH) : '0;
    localparam logic signed [AW:0] YMAX = (AW+1)'((64'sd1 <<< (OW - 1)) - 64'sd1);
    localparam logic signed [AW:0] YMIN = -YMAX - (AW+1)'(1);

    typedef logic signed [CW-1:0] coef_t;
    typedef coef_t [NT-1:0]       bank_t;
    typedef logic signed [IW-1:0] smp_t;

    bank_t bank0 = '0;
    bank_t bank1 = '0;
    logic  sel   = 1'b0;

    logic [XW-1:0] idx;
    logic          shadow_valid;
    logic          swap;
    logic          wr_en;
    logic          tlast_ok;
    bank_t         act;

    assign swap     = s_axis_config_tvalid && shadow_valid;
    assign wr_en    = s_axis_reload_tvalid && (idx != XW'(NT));
    assign tlast_ok = (idx == XW'(NT - 1));
    assign act      = sel ? bank1 : bank0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            idx                  <= '0;
            shadow_valid         <= 1'b0;
            event_reload_err     <= 1'b0;
            event_config_ignored <= 1'b0;
        end else begin
            event_reload_err     <= s_axis_reload_tvalid && s_axis_reload_tlast
                                    && !tlast_ok;
            event_config_ignored <= s_axis_config_tvalid && !shadow_valid;
            if (swap) shadow_valid <= 1'b0;
            if (s_axis_reload_tvalid) begin
                if (s_axis_reload_tlast) begin
                    idx          <= '0;
                    shadow_valid <= tlast_ok;
                end else if (wr_en) begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (aresetn) begin
            if (wr_en) begin
                if (sel) bank0[idx[AX-1:0]] <= s_axis_reload_tdata;
                else     bank1[idx[AX-1:0]] <= s_axis_reload_tdata;
            end
            if (swap) sel <= ~sel;
        end
    end

    smp_t dline [DP][NT];
    logic v1;
    logic [OW*DP-1:0] y;

    always_comb begin
        logic signed [PW-1:0] p;
        logic signed [AW-1:0] acc;
        logic signed [AW:0]   rnd;
        logic signed [AW:0]   shf;
        y   = '0;
        p   = '0;
        acc = '0;
        rnd = '0;
        shf = '0;
        for (int k = 0; k < DP; k++) begin
            acc = '0;
            for (int j = 0; j < NT; j++) begin
                p   = PW'($signed(act[j])) * PW'(dline[k][j]);
                acc = acc + AW'(p);
            end
            rnd = (AW+1)'(acc) + RND;
            shf = rnd >>> SH;
`ifdef FIR_RELOAD_SAT_SATURATE_EN
            if (shf > YMAX)      shf = YMAX;
            else if (shf < YMIN) shf = YMIN;
`endif
            y[k*OW +: OW] = shf[OW-1:0];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v1                 <= 1'b0;
            m_axis_data_tvalid <= 1'b0;
            m_axis_data_tdata  <= '0;
            for (int k = 0; k < DP; k++)
                for (int j = 0; j < NT; j++)
                    dline[k][j] <= '0;
        end else begin
            v1                 <= s_axis_data_tvalid;
            m_axis_data_tvalid <= v1;
            if (v1) m_axis_data_tdata <= y;
            if (s_axis_data_tvalid) begin
                for (int k = 0; k < DP; k++) begin
                    dline[k][0] <= s_axis_data_tdata[k*IW +: IW];
                    for (int j = 1; j < NT; j++)
                        dline[k][j] <= dline[k][j-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_reload_sat.sv
// Bench for fir_reload_sat: vector table, directed corner cases, random run
// against a behavioural model of the filter and reload protocol.
`timescale 1ns/1ps
module tb_fir_reload_sat;

    localparam int NT = 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        s_axis_reload_tvalid;
    logic        s_axis_reload_tlast;
    logic [15:0] s_axis_reload_tdata;
    logic        s_axis_config_tvalid;
    logic        s_axis_data_tvalid;
    logic [31:0] s_axis_data_tdata;
    logic        m_axis_data_tvalid;
    logic [31:0] m_axis_data_tdata;
    logic        event_reload_err;
    logic        event_config_ignored;

    always #5 aclk = ~aclk;

    fir_reload_sat #(
        .C_S_DATA_TDATA_WIDTH(16),
        .C_M_DATA_TDATA_WIDTH(16),
        .C_RELOAD_TDATA_WIDTH(16),
        .DATA_PATH(2),
        .C_NUM_TAPS(NT),
        .C_OUT_SHIFT(15),
        .C_COEF_FILE("")
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_axis_reload_tvalid(s_axis_reload_tvalid),
        .s_axis_reload_tlast(s_axis_reload_tlast),
        .s_axis_reload_tdata(s_axis_reload_tdata),
        .s_axis_config_tvalid(s_axis_config_tvalid),
        .s_axis_data_tvalid(s_axis_data_tvalid),
        .s_axis_data_tdata(s_axis_data_tdata),
        .m_axis_data_tvalid(m_axis_data_tvalid),
        .m_axis_data_tdata(m_axis_data_tdata),
        .event_reload_err(event_reload_err),
        .event_config_ignored(event_config_ignored)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          act [NT];
    int          shd [NT];
    bit          m_sv;
    int          m_idx;
    int          hist0 [$];
    int          hist1 [$];
    bit          ea_v, eb_v;
    logic [31:0] ea_d, eb_d;
    bit          ev_err, ev_ign;

    typedef struct {
        bit          dv;
        logic [15:0] d0, d1;
        bit          rv, rl;
        logic [15:0] rd;
        bit          cfg;
        bit          ev;
        logic [15:0] e0, e1;
        bit          eerr, eign;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    function automatic logic [15:0] model_y(input int ch);
        longint acc = 0;
        longint r;
        for (int j = 0; j < NT; j++) begin
            if (ch == 0 && j < hist0.size()) acc += longint'(act[j]) * longint'(hist0[j]);
            if (ch == 1 && j < hist1.size()) acc += longint'(act[j]) * longint'(hist1[j]);
        end
        r = (acc + 16384) >>> 15;
`ifdef FIR_RELOAD_SAT_SATURATE_EN
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    task automatic model_clear();
        hist0.delete();
        hist1.delete();
        m_sv = 0; m_idx = 0;
        ea_v = 0; eb_v = 0; ea_d = '0; eb_d = '0;
        ev_err = 0; ev_ign = 0;
    endtask

    task automatic cycle(input bit dv, input logic [15:0] d0, input logic [15:0] d1,
                         input bit rv, input bit rl, input logic [15:0] rd,
                         input bit cfg);
        bit swap;
        int t;
        @(posedge aclk);
        #1;
        s_axis_data_tvalid   = dv;
        s_axis_data_tdata    = {d1, d0};
        s_axis_reload_tvalid = rv;
        s_axis_reload_tlast  = rl;
        s_axis_reload_tdata  = rd;
        s_axis_config_tvalid = cfg;
        @(negedge aclk);
        chk("tvalid", m_axis_data_tvalid, ea_v);
        if (ea_v) chk("tdata", m_axis_data_tdata, ea_d);
        else      chk("tdata_hold", m_axis_data_tdata, ea_d);
        chk("reload_err", event_reload_err, ev_err);
        chk("cfg_ignored", event_config_ignored, ev_ign);

        ev_ign = cfg && !m_sv;
        swap   = cfg && m_sv;
        ev_err = 0;
        if (rv && m_idx < NT) shd[m_idx] = int'($signed(rd));
        if (swap) begin
            for (int j = 0; j < NT; j++) begin
                t = act[j]; act[j] = shd[j]; shd[j] = t;
            end
            m_sv = 0;
        end
        if (rv) begin
            if (rl) begin
                ev_err = (m_idx != NT - 1);
                m_sv   = !ev_err;
                m_idx  = 0;
            end else if (m_idx < NT) begin
                m_idx++;
            end
        end

        ea_v = eb_v;
        ea_d = eb_d;
        if (dv) begin
            hist0.push_front(int'($signed(d0)));
            hist1.push_front(int'($signed(d1)));
            if (hist0.size() > NT) void'(hist0.pop_back());
            if (hist1.size() > NT) void'(hist1.pop_back());
            eb_v = 1;
            eb_d = {model_y(1), model_y(0)};
        end else begin
            eb_v = 0;
            eb_d = ea_d;
        end
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #1;
        s_axis_data_tvalid   = 0;
        s_axis_reload_tvalid = 0;
        s_axis_reload_tlast  = 0;
        s_axis_config_tvalid = 0;
        aresetn              = 0;
        #1;
        chk("rst_tvalid", m_axis_data_tvalid, 0);
        chk("rst_tdata", m_axis_data_tdata, 0);
        chk("rst_err", event_reload_err, 0);
        chk("rst_ign", event_config_ignored, 0);
        repeat (3) @(posedge aclk);
        #1 aresetn = 1;
        model_clear();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          dv, rv, rl, cfg;
        logic [15:0] d0, d1, rd;
        logic [15:0] ovf;
        logic [15:0] nc [NT];
        int          blen;
        int          r;

        aresetn              = 0;
        s_axis_data_tvalid   = 0;
        s_axis_data_tdata    = '0;
        s_axis_reload_tvalid = 0;
        s_axis_reload_tlast  = 0;
        s_axis_reload_tdata  = '0;
        s_axis_config_tvalid = 0;
        for (int j = 0; j < NT; j++) begin act[j] = 0; shd[j] = 0; end
        model_clear();

        repeat (2) @(posedge aclk);
        #1;
        chk("rst0_tvalid", m_axis_data_tvalid, 0);
        chk("rst0_tdata", m_axis_data_tdata, 0);
        aresetn = 1;

        // Impulse on ch0, constant 0x1000 on ch1
        tbl[0]  = '{0, 16'h0000, 16'h0000, 1, 0, 16'h4000, 0, 0, 16'h0000, 16'h0000, 0, 0};
        tbl[1]  = '{0, 16'h0000, 16'h0000, 1, 0, 16'h2000, 0, 0, 16'h0000, 16'h0000, 0, 0};
        tbl[2]  = '{0, 16'h0000, 16'h0000, 1, 0, 16'h1000, 0, 0, 16'h0000, 16'h0000, 0, 0};
        tbl[3]  = '{0, 16'h0000, 16'h0000, 1, 1, 16'h0800, 0, 0, 16'h0000, 16'h0000, 0, 0};
        tbl[4]  = '{0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0};
        tbl[5]  = '{1, 16'h7FFF, 16'h1000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0};
        tbl[6]  = '{1, 16'h0000, 16'h1000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0};
        tbl[7]  = '{1, 16'h0000, 16'h1000, 0, 0, 16'h0000, 0, 1, 16'h4000, 16'h0800, 0, 0};
        tbl[8]  = '{1, 16'h0000, 16'h1000, 0, 0, 16'h0000, 0, 1, 16'h2000, 16'h0C00, 0, 0};
        tbl[9]  = '{1, 16'h0000, 16'h1000, 0, 0, 16'h0000, 0, 1, 16'h1000, 16'h0E00, 0, 0};
        tbl[10] = '{0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0800, 16'h0F00, 0, 0};
        tbl[11] = '{0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 16'h0F00, 0, 0};
        tbl[12] = '{0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0F00, 0, 0};

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].dv, tbl[i].d0, tbl[i].d1, tbl[i].rv, tbl[i].rl,
                  tbl[i].rd, tbl[i].cfg);
            chk("tbl_tvalid", m_axis_data_tvalid, tbl[i].ev);
            chk("tbl_ch0", m_axis_data_tdata[15:0], tbl[i].e0);
            chk("tbl_ch1", m_axis_data_tdata[31:16], tbl[i].e1);
            chk("tbl_err", event_reload_err, tbl[i].eerr);
            chk("tbl_ign", event_config_ignored, tbl[i].eign);
        end

        // Malformed reload: 3 words then a refused swap
        cycle(0, 0, 0, 1, 0, 16'h1111, 0);
        cycle(0, 0, 0, 1, 0, 16'h2222, 0);
        cycle(0, 0, 0, 1, 1, 16'h3333, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("malformed_err", event_reload_err, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("malformed_ign", event_config_ignored, 1);
        cycle(1, 16'h7FFF, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        chk("old_bank_kept", m_axis_data_tdata[15:0], 16'h4000);
        repeat (4) cycle(0, 0, 0, 0, 0, 0, 0);

        // Overflow: all taps and input at full scale
`ifdef FIR_RELOAD_SAT_SATURATE_EN
        ovf = 16'h7FFF;
`else
        ovf = 16'hFFF8;
`endif
        for (int i = 0; i < NT; i++) cycle(0, 0, 0, 1, i == NT - 1, 16'h7FFF, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 16'h7FFF, 16'h7FFF, 0, 0, 0, 0);
            if (i == 5) chk("overflow_4th", m_axis_data_tdata[15:0], ovf);
        end
        cycle(1, 16'h7FFF, 16'h7FFF, 0, 0, 0, 0);
        chk("overflow_5th", m_axis_data_tdata[31:16], ovf);

        // Swap while streaming: config in the same cycle as sample 5
        nc[0] = 16'h0100; nc[1] = 16'h0200; nc[2] = 16'h0300; nc[3] = 16'h0400;
        for (int i = 0; i < 10; i++) begin
            cycle(1, 16'h0100, 16'h0100, i < NT, i == NT - 1,
                  (i < NT) ? nc[i] : 16'h0000, i == 5);
            if (i == 6) chk("swap_old_bank", m_axis_data_tdata[15:0], 16'h0400);
            if (i == 7) chk("swap_new_bank", m_axis_data_tdata[15:0], 16'h0014);
        end

        // Reset mid-stream, then a clean impulse
        cycle(1, 16'h1234, 16'h4321, 0, 0, 0, 0);
        cycle(1, 16'h7000, 16'h8000, 0, 0, 0, 0);
        do_reset();
        cycle(1, 16'h7FFF, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        chk("post_reset_h0", m_axis_data_tdata[15:0], 16'h0100);
        cycle(1, 0, 0, 0, 0, 0, 0);
        chk("post_reset_h1", m_axis_data_tdata[15:0], 16'h0200);
        repeat (4) cycle(0, 0, 0, 0, 0, 0, 0);

        // Random traffic against the model
        blen = 0;
        for (int c = 0; c < 600; c++) begin
            dv  = ($urandom_range(0, 3) != 0);
            d0  = 16'($urandom);
            d1  = 16'($urandom);
            rd  = 16'($urandom);
            cfg = ($urandom_range(0, 14) == 0);
            rv  = 0;
            rl  = 0;
            if (blen == 0 && $urandom_range(0, 15) == 0) begin
                r = $urandom_range(0, 9);
                if (r < 6)       blen = 4;
                else if (r < 8)  blen = 3;
                else if (r == 8) blen = 5;
                else             blen = 6;
            end
            if (blen > 0 && $urandom_range(0, 3) != 0) begin
                rv = 1;
                rl = (blen == 1);
                blen--;
            end
            cycle(dv, d0, d1, rv, rl, rd, cfg);
        end
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
